alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width; any value of 8 or more that is a power of two.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5, operation select width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, aborts any accepted operation.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 SHALL have port SrcA, input, DATA_WIDTH, first operand.
REQ-009 SHALL have port SrcB, input, DATA_WIDTH, second operand.
REQ-010 SHALL have port Operation, input, OPCODE_LENGTH, operation select.
REQ-011 SHALL have port out_valid, output, 1, ALUResult holds a valid result.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 SHALL have port ALUResult, output, DATA_WIDTH, registered result.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, CALC and DONE; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-016 SHALL accept a request on a clock edge only when in_valid and in_ready are both high, and SHALL latch SrcA, SrcB and Operation at that edge.
REQ-017 SHALL decode single-cycle codes 0x00..0x0E as follows: AND, OR, pass SrcB, XOR, SLL, SRL, unsigned <, unsigned >=, ==, !=, SUB, ADD, signed <, SRA, constant 1.
REQ-018 SHALL use only the low log2(DATA_WIDTH) bits of SrcB as the shift amount for SLL, SRL and SRA.
REQ-019 SHALL zero-extend compare results to DATA_WIDTH, giving 0 or 1.
REQ-020 SHALL register a single-cycle result at the accept edge and go directly to DONE, so out_valid is high in the cycle after the accept.
REQ-021 SHALL decode iterative codes 0x10..0x17 as MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RISC-V M semantics.
REQ-022 SHALL go from IDLE to CALC on accepting an iterative code and run exactly DATA_WIDTH iterations, one per cycle: shift-add for multiply, restoring divide for divide.
REQ-023 SHALL use a 2*DATA_WIDTH-bit product; MUL returns the low half, MULH/MULHSU/MULHU return the high half with sign handling per operand.
REQ-024 SHALL use an internal iteration counter that runs 0..DATA_WIDTH-1; on the final iteration it SHALL go CALC->DONE and load ALUResult, so out_valid rises DATA_WIDTH+1 cycles after the accept edge.
REQ-025 SHALL handle divide by zero without iterating: go straight to DONE in the next cycle, with quotient = all ones and remainder = SrcA.
REQ-026 SHALL handle signed overflow (DIV/REM of the most-negative value by -1) without iterating: go straight to DONE, with quotient = the most-negative value and remainder = 0.
REQ-027 SHALL treat OPCODE 0x0F, 0x18..max and any undefined code as single-cycle with result 0.
REQ-028 SHALL hold DONE and ALUResult stable while out_ready is low, and SHALL go DONE->IDLE on out_valid and out_ready both high; no new request is accepted at that same edge (one bubble cycle).
REQ-029 SHALL, on flush high at an edge, go to IDLE from any state, discard the operation, and keep ALUResult unchanged; flush SHALL take priority over accept and completion in the same cycle.
REQ-030 SHALL ignore SrcA, SrcB and Operation changes after the accept edge.

Reset
REQ-031 SHALL, on rst_n low at a clock edge, force state=IDLE, counter=0, ALUResult=0, out_valid=0, busy=0 and in_ready=1; rst_n SHALL override flush and any in-flight operation.
REQ-032 SHALL make in_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-033 SHALL be verified with ADD 0x7FFFFFFF+1 accepted, out_ready=1 -> out_valid in the next cycle, ALUResult=0x80000000, then in_ready=1 the cycle after.
REQ-034 SHALL be verified with MULH 0xFFFFFFFF*0xFFFFFFFF and MULHU of the same operands -> 0x00000000 and 0xFFFFFFFE respectively, with out_valid exactly 33 cycles after the accept.
REQ-035 SHALL be verified with DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; each with out_valid one cycle after the accept.
REQ-036 SHALL be verified with DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, and out_ready held low 5 cycles -> out_valid and ALUResult stable for the whole stall.
REQ-037 SHALL be verified with flush pulsed at iteration 10 of MUL -> IDLE next cycle, out_valid never rises, ALUResult unchanged, and the next ADD 2+3 -> 5.
REQ-038 SHALL be verified with rst_n pulled low mid-DIVU -> IDLE, ALUResult=0 and in_ready=1, and SRA 0x80000000 by SrcB=0x21 -> 0xC0000000, using shift amount 1.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: ALU with single-cycle logic/shift/compare/add operations and
// iterative RISC-V M-extension multiply/divide (one bit per clock).
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   flush      - abort any accepted operation, return to IDLE
//   in_valid   - request present on SrcA/SrcB/Operation
//   in_ready   - high in IDLE, block can accept a request
//   SrcA, SrcB - operands (DATA_WIDTH)
//   Operation  - operation select (OPCODE_LENGTH, at least 5 bits)
//   out_valid  - high in DONE, ALUResult valid
//   out_ready  - consumer takes the result
//   ALUResult  - registered result
//   busy       - high in any state other than IDLE
module alu_muldiv #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [W-1:0]   lo_q, lo_d;      // multiplier / dividend, shifts into product low half / quotient
    logic [W-1:0]   mc_q, mc_d;      // multiplicand / divisor magnitude
    logic [2:0]     sel_q, sel_d;    // low opcode bits of the iterative op
    logic           neg_q, neg_d;    // final result must be negated
    logic [W-1:0]   result_q, result_d;

    // Single-cycle operations; undefined codes give zero.
    function automatic logic [W-1:0] alu_single(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [4:0]   code,
        input logic         hi_zero
    );
        logic [W-1:0]  r;
        logic [SW-1:0] shamt;
        shamt = b[SW-1:0];
        case (code)
            5'h00:   r = a & b;
            5'h01:   r = a | b;
            5'h02:   r = b;
            5'h03:   r = a ^ b;
            5'h04:   r = a << shamt;
            5'h05:   r = a >> shamt;
            5'h06:   r = {{(W-1){1'b0}}, (a < b)};
            5'h07:   r = {{(W-1){1'b0}}, (a >= b)};
            5'h08:   r = {{(W-1){1'b0}}, (a == b)};
            5'h09:   r = {{(W-1){1'b0}}, (a != b)};
            5'h0A:   r = a - b;
            5'h0B:   r = a + b;
            5'h0C:   r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            5'h0D:   r = $signed(a) >>> shamt;
            5'h0E:   r = {{(W-1){1'b0}}, 1'b1};
            default: r = {W{1'b0}};
        endcase
        if (!hi_zero) begin
            r = {W{1'b0}};
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [4:0]   code_s;
    logic         hi_zero_s;
    logic         is_iter_s, is_div_s;
    logic         a_neg_s, b_neg_s;
    logic [W-1:0] a_mag_s, b_mag_s;
    logic         div_zero_s, div_ovf_s;
    logic [W-1:0] special_s;

    // Decode the incoming request and prepare operand magnitudes.
    always_comb begin
        code_s     = Operation[4:0];
        hi_zero_s  = ((Operation >> 3'd5) == {OPCODE_LENGTH{1'b0}});
        is_iter_s  = hi_zero_s && (code_s[4:3] == 2'b10);
        is_div_s   = is_iter_s && code_s[2];
        // Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM.
        a_neg_s    = SrcA[W-1] && ((code_s[2:0] == 3'd1) || (code_s[2:0] == 3'd2) ||
                                   (code_s[2:0] == 3'd4) || (code_s[2:0] == 3'd6));
        b_neg_s    = SrcB[W-1] && ((code_s[2:0] == 3'd1) || (code_s[2:0] == 3'd4) ||
                                   (code_s[2:0] == 3'd6));
        a_mag_s    = a_neg_s ? (~SrcA + {{(W-1){1'b0}}, 1'b1}) : SrcA;
        b_mag_s    = b_neg_s ? (~SrcB + {{(W-1){1'b0}}, 1'b1}) : SrcB;
        div_zero_s = is_div_s && (SrcB == {W{1'b0}});
        div_ovf_s  = is_div_s && !code_s[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) &&
                     (SrcB == {W{1'b1}});
        // Divide exceptions resolve immediately; code bit 1 selects remainder.
        if (div_zero_s) begin
            special_s = code_s[1] ? SrcA : {W{1'b1}};
        end else if (div_ovf_s) begin
            special_s = code_s[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
        end else begin
            special_s = alu_single(SrcA, SrcB, code_s, hi_zero_s);
        end
    end

    logic [W:0]     sum_s;
    logic [W:0]     rem_sh_s;
    logic [W:0]     diff_s;
    logic [W-1:0]   step_hi_s, step_lo_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   final_s;

    // One shift-add or restoring-divide step, plus sign fix-up of the final value.
    always_comb begin
        sum_s    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(W+1){1'b0}});
        rem_sh_s = {hi_q, lo_q[W-1]};
        diff_s   = rem_sh_s - {1'b0, mc_q};
        if (sel_q[2]) begin
            // diff_s[W] is the borrow: set when the shifted remainder is below the divisor.
            step_hi_s = diff_s[W] ? rem_sh_s[W-1:0] : diff_s[W-1:0];
            step_lo_s = {lo_q[W-2:0], ~diff_s[W]};
        end else begin
            step_hi_s = sum_s[W:1];
            step_lo_s = {sum_s[0], lo_q[W-1:1]};
        end
        prod_s = {step_hi_s, step_lo_s};
        if (neg_q) begin
            prod_s = ~prod_s + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
            prod_s = prod_s;
        end
        case (sel_q)
            3'd0:    final_s = prod_s[W-1:0];
            3'd1,
            3'd2,
            3'd3:    final_s = prod_s[2*W-1:W];
            3'd4,
            3'd5:    final_s = neg_q ? (~step_lo_s + {{(W-1){1'b0}}, 1'b1}) : step_lo_s;
            3'd6,
            3'd7:    final_s = neg_q ? (~step_hi_s + {{(W-1){1'b0}}, 1'b1}) : step_hi_s;
            default: final_s = {W{1'b0}};
        endcase
    end

    // Next-state and datapath update; flush overrides accept and completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        sel_d    = sel_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_iter_s && !div_zero_s && !div_ovf_s) begin
                        state_d = CALC;
                        cnt_d   = {SW{1'b0}};
                        hi_d    = {W{1'b0}};
                        lo_d    = a_mag_s;
                        mc_d    = b_mag_s;
                        sel_d   = code_s[2:0];
                        // Remainder takes the dividend's sign; everything else the XOR.
                        neg_d   = (code_s[2] && code_s[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
                    end else begin
                        state_d  = DONE;
                        result_d = special_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                cnt_d = cnt_q + {{(SW-1){1'b0}}, 1'b1};
                if (cnt_q == SW'(W-1)) begin
                    state_d  = DONE;
                    result_d = final_s;
                    cnt_d    = {SW{1'b0}};
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = {SW{1'b0}};
            result_d = result_q;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= {SW{1'b0}};
            hi_q     <= {W{1'b0}};
            lo_q     <= {W{1'b0}};
            mc_q     <= {W{1'b0}};
            sel_q    <= 3'd0;
            neg_q    <= 1'b0;
            result_q <= {W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mc_q     <= mc_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign ALUResult = result_q;

endmodule
